keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives the columns of the 4x4 matrix keypad and samples its rows.
- Emits the 5-bit key code consumed by the debouncer: bit 4 = 1 means no key; bits [3:0] = hex key value.
- Sits between the keypad I/O pins and the debouncer.
- Locks onto the first key it detects and reports that key until it is released.

Parameters:
- SETTLE_CYCLES, 1200, clk cycles to wait after driving a column before sampling the rows (100 us at 12 MHz). Must be >= 4.
- CNT_W, 11, counter width. Must satisfy 2**CNT_W >= SETTLE_CYCLES.

Ports:
- clk  input  1  system clock (12 MHz).
- reset  input  1  synchronous, active-high reset.
- rows  input  4  raw keypad row pins, asynchronous, active-low (pulled up); row r low = key in driven column pressed.
- cols  output  4  column drive, active-low, exactly one bit low at all times.
- button  output  5  {no_key, code[3:0]}; 5'b10000 = no key pressed.
- new_key  output  1  one-cycle pulse on the cycle button first shows a newly locked key.

Behaviour:
- Synchronizer: rows pass through a 2-flop synchronizer (rows_s) before any use. All decisions use rows_s.
- Reset values: cols=4'b1110 (col 0), button=5'b10000, new_key=0, state=SCAN, col index=0, counters=0, synchronizer flops=4'b1111.
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- FSM has two states: SCAN and LOCKED.
- SCAN:
  - Drive column c low. Counter increments from 0 each cycle.
  - When counter == SETTLE_CYCLES-1, sample rows_s.
  - If any bit is 0: lowest-index low row r wins. On the next cycle: button={1'b0, map(r,c)}, new_key=1, state=LOCKED, locked row=r, column held at c, release counter=0.
  - If no bit is 0: on the next cycle advance to c=(c+1) mod 4 (3 wraps to 0), counter=0.
- LOCKED:
  - Keep driving column c. button holds its value and new_key=0.
  - Each cycle: if rows_s[r]==1, increment the release counter; else clear it to 0.
  - Other rows and their changes are ignored, including second keys in the same column.
  - When the release counter == SETTLE_CYCLES-1 and rows_s[r]==1: on the next cycle button=5'b10000, state=SCAN, c=(c+1) mod 4, counter=0.
- Latency: a stable press is reported at most 4*SETTLE_CYCLES+1 cycles after it reaches rows_s.
- button changes only on lock/release transitions. No glitch values; never two different codes without an intervening 5'b10000.
- new_key is asserted only on the SCAN->LOCKED transition cycle.
- Reset mid-operation (either state): all state returns to the reset values on the next clock edge. No new_key pulse.
- Counter arithmetic is unsigned CNT_W bits; it never wraps, because it clears before reaching 2**CNT_W.

Test Plan (SETTLE_CYCLES=8):
- Idle: rows=4'b1111 after reset.
  - cols cycles 1110->1101->1011->0111->1110, each held 8 cycles.
  - button stays 5'b10000; new_key never asserts.
- Single press: rows[1]=0 only while cols=4'b1011 (col 2), held long.
  - button=5'b00110 (key 6) with a 1-cycle new_key.
  - cols stays 4'b1011 while held.
  - Release rows=1111: after 8 high cycles of rows_s, button=5'b10000 and cols=4'b0111.
- Bounce on release: in LOCKED, toggle rows[r] high 5 cycles / low 1 cycle repeatedly.
  - button holds the code; release happens only after 8 consecutive high cycles.
- Simultaneous keys: rows=4'b0110 (rows 0 and 3) while cols=4'b0111 (col 3).
  - button=5'b01010 (key A, row 0 wins).
  - Releasing row 3 only changes nothing; releasing row 0 returns button to 5'b10000.
- Wrap and key 0: press row3/col1 (rows[3]=0 while cols=4'b1101).
  - button=5'b00000 (key 0); bit 4 must be 0, not confused with no-key.
  - After release, scanning resumes at col 2, then wraps 3->0.
- Reset mid-lock: assert reset while LOCKED with key held.
  - Next cycle: button=5'b10000, cols=4'b1110, new_key=0.
  - Key still held: it is re-detected when col scan reaches it, with a fresh new_key pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, samples the
// synchronized rows, locks onto the first key found and holds it until release.
module keypad_scanner #(
  parameter int unsigned SETTLE_CYCLES = 1200,
  parameter int unsigned CNT_W         = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [4:0] button,
  output logic       new_key
);

  typedef enum logic {SCAN, LOCKED} state_t;

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [4:0]       NO_KEY = 5'b10000;

  logic [3:0]       rows_meta;
  logic [3:0]       rows_s;
  state_t           state;
  state_t           state_n;
  logic [1:0]       col_idx;
  logic [1:0]       col_idx_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] rel_cnt;
  logic [CNT_W-1:0] rel_cnt_n;
  logic [1:0]       lock_row;
  logic [1:0]       lock_row_n;
  logic [4:0]       button_n;
  logic             new_key_n;
  logic             any_low;
  logic [1:0]       low_row;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_meta <= '1;
      rows_s    <= '1;
    end else begin
      rows_meta <= rows;
      rows_s    <= rows_meta;
    end
  end

  always_comb begin
    any_low = ~&rows_s;
    casez (rows_s)
      4'b???0: low_row = 2'd0;
      4'b??01: low_row = 2'd1;
      4'b?011: low_row = 2'd2;
      4'b0111: low_row = 2'd3;
      default: low_row = 2'd0;
    endcase
  end

  always_comb begin
    cols = ~(4'b0001 << col_idx);
  end

  always_comb begin
    state_n    = state;
    col_idx_n  = col_idx;
    cnt_n      = cnt;
    rel_cnt_n  = rel_cnt;
    lock_row_n = lock_row;
    button_n   = button;
    new_key_n  = 1'b0;
    case (state)
      SCAN: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          cnt_n = '0;
          if (any_low) begin
            state_n    = LOCKED;
            lock_row_n = low_row;
            rel_cnt_n  = '0;
            button_n   = {1'b0, key_map(low_row, col_idx)};
            new_key_n  = 1'b1;
          end else begin
            col_idx_n = col_idx + 2'd1;
          end
        end
      end
      LOCKED: begin
        // Only the locked row matters; any low sample restarts the release window.
        if (rows_s[lock_row]) begin
          if (rel_cnt == LAST) begin
            state_n   = SCAN;
            button_n  = NO_KEY;
            col_idx_n = col_idx + 2'd1;
            cnt_n     = '0;
            rel_cnt_n = '0;
          end else begin
            rel_cnt_n = rel_cnt + CNT_W'(1);
          end
        end else begin
          rel_cnt_n = '0;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SCAN;
      col_idx  <= '0;
      cnt      <= '0;
      rel_cnt  <= '0;
      lock_row <= '0;
      button   <= NO_KEY;
      new_key  <= 1'b0;
    end else begin
      state    <= state_n;
      col_idx  <= col_idx_n;
      cnt      <= cnt_n;
      rel_cnt  <= rel_cnt_n;
      lock_row <= lock_row_n;
      button   <= button_n;
      new_key  <= new_key_n;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows from the
// strobed columns; expected button events are queued and checked by a monitor.
module tb_keypad_scanner;

  localparam int unsigned S = 8;
  localparam logic [4:0] NO_KEY = 5'b10000;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [4:0] button;
  logic       new_key;

  keypad_scanner #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .button(button), .new_key(new_key)
  );

  always #5 clk = ~clk;

  // keys[r][c] = 1 means the key at row r, column c is physically held down
  logic [3:0] keys [4];
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  always_comb begin
    for (int r = 0; r < 4; r++) rows[r] = ~|(keys[r] & ~cols);
  end

  int total  = 0;
  int passed = 0;
  logic [4:0] sb [$];
  bit         mon_en = 1'b0;
  logic [4:0] prev_button;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [4:0] code_of(input int r, input int c);
    return {1'b0, keymap[r*4 + c]};
  endfunction

  function automatic logic [3:0] col_drive(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  // Monitor: every button change must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      check("cols_one_low", $countones(cols), 3);
      if (button !== prev_button) begin
        if (sb.size() == 0) begin
          check("unexpected_button_change", button, prev_button);
        end else begin
          check("button_event", button, sb.pop_front());
        end
        check("new_key_on_change", new_key, button !== NO_KEY);
      end else begin
        check("new_key_quiet", new_key, 1'b0);
      end
      prev_button = button;
    end
  end

  task automatic wait_drain(input int limit, input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() == 0) passed++;
    else begin
      $display("FAIL %s: timeout after %0d cycles, %0d events outstanding", name, n, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_cols_change(input int limit, output logic [3:0] now, output int n);
    logic [3:0] start;
    start = cols;
    n = 0;
    while (cols === start && n < limit) begin
      @(negedge clk);
      n++;
    end
    now = cols;
  endtask

  task automatic press_release(input int r, input int c, input int hold);
    sb.push_back(code_of(r, c));
    keys[r][c] = 1'b1;
    wait_drain(4*S + 6, "lock_latency");
    check("locked_col", cols, col_drive(c));
    repeat (hold) @(negedge clk);
    check("held_code", button, code_of(r, c));
    keys[r][c] = 1'b0;
    sb.push_back(NO_KEY);
    repeat (S) @(negedge clk);
    check("no_early_release", button, code_of(r, c));
    wait_drain(6, "release_latency");
    check("next_col_after_release", cols, col_drive((c + 1) % 4));
  endtask

  logic [3:0] nc;
  int         len;

  initial begin
    for (int r = 0; r < 4; r++) keys[r] = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_button", button, NO_KEY);
    check("reset_cols", cols, 4'b1110);
    check("reset_new_key", new_key, 1'b0);
    prev_button = button;
    mon_en = 1'b1;
    reset = 1'b0;

    // Idle: full column rotation, each column held for S cycles
    wait_cols_change(20, nc, len);
    check("idle_first_step", nc, 4'b1101);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] want;
      want = col_drive((i + 2) % 4);
      wait_cols_change(20, nc, len);
      check("idle_col_dwell", len, S);
      check("idle_col_next", nc, want);
    end
    check("idle_button", button, NO_KEY);

    // Single press: key 6 at row 1, col 2
    press_release(1, 2, 20);

    // Release bounce on key 7 (row 2, col 0)
    sb.push_back(code_of(2, 0));
    keys[2][0] = 1'b1;
    wait_drain(4*S + 6, "bounce_lock");
    for (int i = 0; i < 4; i++) begin
      keys[2][0] = 1'b0;
      repeat (5) @(negedge clk);
      keys[2][0] = 1'b1;
      @(negedge clk);
    end
    check("bounce_hold", button, code_of(2, 0));
    keys[2][0] = 1'b0;
    sb.push_back(NO_KEY);
    wait_drain(S + 6, "bounce_release");

    // Two keys in column 3: row 0 (A) wins, row 3 ignored
    sb.push_back(5'b01010);
    keys[0][3] = 1'b1;
    keys[3][3] = 1'b1;
    wait_drain(4*S + 6, "simul_lock");
    check("simul_cols", cols, 4'b0111);
    keys[3][3] = 1'b0;
    repeat (2*S + 4) @(negedge clk);
    check("simul_other_release", button, 5'b01010);
    keys[0][3] = 1'b0;
    sb.push_back(NO_KEY);
    wait_drain(S + 6, "simul_release");
    check("simul_wrap_col", cols, 4'b1110);

    // Key 0 (row 3, col 1), then scan resumes at col 2 and wraps
    sb.push_back(5'b00000);
    keys[3][1] = 1'b1;
    wait_drain(4*S + 6, "key0_lock");
    check("key0_bit4", button[4], 1'b0);
    keys[3][1] = 1'b0;
    sb.push_back(NO_KEY);
    wait_drain(S + 6, "key0_release");
    check("key0_resume_col", cols, 4'b1011);
    wait_cols_change(20, nc, len);
    check("key0_next_col", nc, 4'b0111);
    wait_cols_change(20, nc, len);
    check("key0_wrap_col", nc, 4'b1110);

    // Reset while locked; held key is found again with a fresh pulse
    sb.push_back(code_of(1, 1));
    keys[1][1] = 1'b1;
    wait_drain(4*S + 6, "prereset_lock");
    sb.push_back(NO_KEY);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_button", button, NO_KEY);
    check("midreset_cols", cols, 4'b1110);
    check("midreset_new_key", new_key, 1'b0);
    reset = 1'b0;
    sb.push_back(code_of(1, 1));
    wait_drain(4*S + 6, "relock_after_reset");
    keys[1][1] = 1'b0;
    sb.push_back(NO_KEY);
    wait_drain(S + 6, "release_after_reset");

    // Random single keys with random hold and gap
    for (int i = 0; i < 10; i++) begin
      int r, c;
      r = int'($urandom_range(3, 0));
      c = int'($urandom_range(3, 0));
      press_release(r, c, int'($urandom_range(20, 0)));
      repeat ($urandom_range(40, 0)) @(negedge clk);
    end

    repeat (4*S) @(negedge clk);
    check("final_queue_empty", sb.size(), 0);
    check("final_button", button, NO_KEY);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
